// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters and the 8-way arbiter.
// The master drives requests and done; the slave returns the grant.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-input round-robin arbiter with registered one-hot grant.
// Grants are held until done, request drop or the hold limit.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_8_if.slave bus
);

  localparam logic [7:0] HOLD = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] owner, owner_n;
  logic [7:0] hold_cnt, cnt_n;
  logic [7:0] gnt_q, gnt_n;
  logic       to_q, to_n;

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  off;
  logic [2:0]  sel;
  logic        hit;

  // Rotate so bit 0 is the current highest-priority requester.
  always_comb begin
    dbl = {bus.req, bus.req};
    rot = 8'(dbl >> ptr);
    off = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (rot[j]) off = 3'(j);
    end
    sel = ptr + off;
  end

  assign hit = (HOLD != 8'd0) && (hold_cnt == HOLD);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = hold_cnt;
    gnt_n   = gnt_q;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n = 8'd0;
        if (|bus.req) begin
          state_n = GRANT;
          owner_n = sel;
          gnt_n   = 8'd1 << sel;
          cnt_n   = 8'd1;
          ptr_n   = sel + 3'd1;
        end
      end
      GRANT: begin
        if (bus.done || !bus.req[owner]) begin
          state_n = IDLE;
          gnt_n   = 8'd0;
        end else if (hit) begin
          state_n = IDLE;
          gnt_n   = 8'd0;
          to_n    = 1'b1;
        end else begin
          cnt_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      owner    <= 3'd0;
      hold_cnt <= 8'd0;
      gnt_q    <= 8'd0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
      hold_cnt <= cnt_n;
      gnt_q    <= gnt_n;
      to_q     <= to_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: three hold limits (16, 4, 0) driven in
// parallel, checked against a behavioural model and directed values.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8_if if16 ();
  rr_arbiter_8_if if4 ();
  rr_arbiter_8_if if0 ();

  assign if16.req  = req;
  assign if16.done = done;
  assign if4.req   = req;
  assign if4.done  = done;
  assign if0.req   = req;
  assign if0.done  = done;

  rr_arbiter_8 #(.MAX_HOLD(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
  rr_arbiter_8 #(.MAX_HOLD(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
  rr_arbiter_8 #(.MAX_HOLD(0))  u0  (.clk(clk), .rst(rst), .bus(if0));

  always #5 clk = ~clk;

  logic [7:0] g [3];
  logic       gv [3];
  logic       to [3];

  assign g[0]  = if16.gnt;
  assign g[1]  = if4.gnt;
  assign g[2]  = if0.gnt;
  assign gv[0] = if16.gnt_valid;
  assign gv[1] = if4.gnt_valid;
  assign gv[2] = if0.gnt_valid;
  assign to[0] = if16.timeout;
  assign to[1] = if4.timeout;
  assign to[2] = if0.timeout;

  // Reference model: who holds the grant, for how long, next in line.
  int hmax [3] = '{16, 4, 0};
  bit busy [3];
  int own  [3];
  int nxt  [3];
  int held [3];
  bit mto  [3];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    if (rst) begin
      busy[k] = 0; own[k] = 0; nxt[k] = 0; held[k] = 0; mto[k] = 0;
    end else if (!busy[k]) begin
      mto[k] = 0;
      if (req != 8'd0) begin
        for (int n = 0; n < 8; n++) begin
          int i;
          i = (nxt[k] + n) % 8;
          if (req[i] && !busy[k]) begin
            busy[k] = 1; own[k] = i; held[k] = 1;
            nxt[k] = (i + 1) % 8;
          end
        end
      end
    end else begin
      mto[k] = 0;
      if (done || !req[own[k]]) busy[k] = 0;
      else if (hmax[k] != 0 && held[k] == hmax[k]) begin
        busy[k] = 0; mto[k] = 1;
      end else held[k]++;
    end
  endtask

  task automatic tick();
    logic [7:0] eg;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    for (int k = 0; k < 3; k++) begin
      eg = busy[k] ? (8'd1 << own[k]) : 8'd0;
      chk($sformatf("gnt[%0d]", k), g[k], eg);
      chk($sformatf("valid[%0d]", k), {7'd0, gv[k]}, {7'd0, busy[k]});
      chk($sformatf("timeout[%0d]", k), {7'd0, to[k]}, {7'd0, mto[k]});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with full request load
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_gnt", g[0], 8'h00);
      chk("rst_to", {7'd0, to[0]}, 8'h00);
    end
    rst = 1'b0;
    tick();
    chk("first_gnt", g[0], 8'h01);
    done = 1'b1; tick(); done = 1'b0;

    // Single request with done at cycle 3
    req = 8'h00; do_reset();
    req = 8'h04;
    tick(); chk("single_c1", g[0], 8'h04);
    tick(); chk("single_c2", g[0], 8'h04);
    tick(); chk("single_c3", g[0], 8'h04);
    done = 1'b1;
    tick(); chk("single_c4", g[0], 8'h00);
    done = 1'b0;
    tick(); chk("single_c5", g[0], 8'h04);

    // Round robin with wrap, done in each first grant cycle
    req = 8'h00; do_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      logic [7:0] e;
      e = 8'h01 << (n % 8);
      tick(); chk($sformatf("rr_gnt%0d", n), g[0], e);
      done = 1'b1;
      tick(); chk($sformatf("rr_gap%0d", n), g[0], 8'h00);
      done = 1'b0;
    end

    // Hold limit: 4 on u4, disabled on u0
    req = 8'h00; do_reset();
    req = 8'h10;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk($sformatf("to4_hold%0d", t), g[1], 8'h10);
      chk($sformatf("to4_nto%0d", t), {7'd0, to[1]}, 8'h00);
      chk($sformatf("to0_hold%0d", t), g[2], 8'h10);
    end
    tick();
    chk("to4_rel", g[1], 8'h00);
    chk("to4_pulse", {7'd0, to[1]}, 8'h01);
    tick();
    chk("to4_regnt", g[1], 8'h10);
    chk("to4_pulse_end", {7'd0, to[1]}, 8'h00);
    for (int t = 0; t < 300; t++) begin
      tick();
      if (g[2] !== 8'h10 || to[2] !== 1'b0) begin
        chk("to0_hold_long", g[2], 8'h10);
        chk("to0_no_timeout", {7'd0, to[2]}, 8'h00);
      end
    end
    chk("to0_final", g[2], 8'h10);

    // Owner drops request; next priority goes to 7
    req = 8'h00; do_reset();
    req = 8'h81;
    tick(); chk("drop_g01", g[0], 8'h01);
    req = 8'h80;
    tick(); chk("drop_rel", g[0], 8'h00);
    chk("drop_nto", {7'd0, to[0]}, 8'h00);
    tick(); chk("drop_g80", g[0], 8'h80);

    // Reset in the middle of a grant clears the pointer
    req = 8'h00; do_reset();
    req = 8'h20;
    tick(); chk("mid_g20", g[0], 8'h20);
    tick(); chk("mid_hold", g[0], 8'h20);
    rst = 1'b1;
    tick(); chk("mid_rst", g[0], 8'h00);
    rst = 1'b0; req = 8'h21;
    tick(); chk("mid_g01", g[0], 8'h01);

    // Randomised traffic against the model
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 9) == 0) req = 8'h00;
      done = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-input round-robin arbiter that sits directly upstream of the 8:3 encoder. It accepts up to eight request lines and issues a registered one-hot grant vector, which the encoder converts to a 3-bit owner index. Grants are held until the owner signals done, drops its request, or exceeds a programmable hold limit. Rotating priority guarantees that no requester starves.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles a grant is held; legal range 0..255; 0 disables the timeout.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request lines; bit i = requester i.
- done  in  1  owner releases the grant; sampled only while a grant is held.
- gnt  out  8  one-hot grant, registered; all-zero when no grant; drives the encoder input directly.
- gnt_valid  out  1  high exactly when gnt is non-zero; consumers must qualify the encoder output with it, because gnt = 0 encodes to 000.
- timeout  out  1  one-cycle pulse, registered, raised when a grant is revoked by the hold limit.

## Operation
- State machine has two states: IDLE and GRANT.
- Registered state:
  - ptr (3 bits): index of the current highest-priority requester.
  - owner (3 bits)
  - hold_cnt (8 bits)
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, … mod 8.
  - Load gnt with that one-hot bit, owner = i, and hold_cnt = 1.
  - Set ptr = (i+1) mod 8 and go to GRANT.
  - If req == 0, stay in IDLE with gnt = 0.
- GRANT, revoke conditions (checked in priority order):
  1. done = 1 → release.
  2. req[owner] = 0 → release.
  3. MAX_HOLD != 0 and hold_cnt == MAX_HOLD → release with timeout.
  4. Otherwise stay in GRANT and increment hold_cnt.
- Release action:
  - Next cycle gnt = 0, gnt_valid = 0, state = IDLE.
  - timeout = 1 for that one cycle only, and only on a timeout-caused release.
- Only the release path leaves GRANT; there is no direct GRANT→GRANT handoff. Exactly one dead cycle separates consecutive grants.
- Wrap-around: a grant to index 7 sets ptr = 0.
- Requests on bits other than owner have no effect during GRANT.
- done while in IDLE is ignored.
- Simultaneous done and hold-limit reached: the release is counted as done, and timeout stays 0.
- gnt is always zero or one-hot; it never carries multiple bits.

## Timing
- Reset values: gnt = 0, gnt_valid = 0, timeout = 0, ptr = 0, owner = 0, hold_cnt = 0, state = IDLE.
- rst has priority over all other inputs, including mid-grant. Outputs are zero on the edge after rst is sampled high.
- Grant latency: req sampled in IDLE at edge N → gnt valid after edge N+1 (1 cycle).
- Release latency: done or the request drop sampled at edge M → gnt = 0 after edge M+1.
- Minimum grant duration is 1 cycle. With MAX_HOLD = H > 0, maximum duration is H cycles.
- Minimum re-grant spacing is 2 cycles: 1 grant cycle + 1 idle cycle.
- Turnaround under full load is H+1 cycles per requester with no done, or 2 cycles with done in the first grant cycle.

## Test plan
- Reset: rst = 1 for 3 cycles with req = 8'hFF and done = 0.
  - Required: gnt = 00000000, gnt_valid = 0, timeout = 0 throughout.
  - After rst drops, the first grant is 00000001.
- Single request: req = 8'b00000100 from cycle 0, done pulsed at cycle 3.
  - Required: gnt = 00000100 and gnt_valid = 1 at cycles 1–3; gnt = 0 at cycle 4.
  - Grant reasserts at cycle 5 if req is still held.
- Round robin with wrap: req = 8'hFF held, done pulsed in every grant's first cycle.
  - Required sequence: 01, 02, 04, 08, 10, 20, 40, 80, 01, each separated by one zero cycle.
- Timeout: MAX_HOLD = 4, req = 8'h10 held, done = 0.
  - Required: gnt = 10 for exactly 4 cycles, then 0 with timeout = 1 for one cycle, then 10 again.
  - Repeat this check with MAX_HOLD = 0: the grant holds indefinitely and timeout stays 0.
- Owner drop and priority: req = 8'h81 from reset.
  - Required: grant 01. Drop req[0] → gnt = 0 next cycle with timeout = 0, then 80 is granted.
- Reset mid-grant: grant 20 held, rst = 1 for one cycle, then req = 8'h21.
  - Required: gnt = 0 the cycle after rst; ptr is reset, so the next grant is 01, not 20.
